// File: rtl/char_select_ctrl.sv
// Character-select menu controller.
// Moves two player cursors over the roster from edge-detected key levels,
// handles lock-in / unlock, runs the pre-match countdown on frame ticks and
// pulses match_start when the countdown expires.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | not in the select screen; cursors kept, locks clear
// S_SELECT  | players move cursors and lock in independently
// S_COUNT   | both locked; countdown decrements on each frame_tick
// S_DONE    | selection final; char nums and locks held for the match
module char_select_ctrl #(
  parameter int NUM_CHARS        = 4,
  parameter int COUNTDOWN_FRAMES = 180
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       menu_enable,
  input  logic       p1_left,
  input  logic       p1_right,
  input  logic       p1_confirm,
  input  logic       p1_cancel,
  input  logic       p2_left,
  input  logic       p2_right,
  input  logic       p2_confirm,
  input  logic       p2_cancel,
  output logic [3:0] Player_One_Char_Num,
  output logic [3:0] Player_Two_Char_Num,
  output logic       p1_locked,
  output logic       p2_locked,
  output logic [7:0] countdown,
  output logic [1:0] select_state,
  output logic       match_start
);

  localparam logic [3:0] LAST_CHAR = 4'(NUM_CHARS - 1);
  localparam logic [7:0] CD_LOAD   = 8'(COUNTDOWN_FRAMES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SELECT = 2'b01,
    S_COUNT  = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  // Key bundle layout: {left, right, confirm, cancel}
  logic [3:0] k1_q, k1_prev_q, k2_q, k2_prev_q;
  logic [3:0] e1, e2;

  state_t     state_q, state_d;
  logic [3:0] n1_q, n1_d, n2_q, n2_d;
  logic       l1_q, l1_d, l2_q, l2_d;
  logic [7:0] cd_q, cd_d;
  logic       ms_q, ms_d;
  logic [4:0] p1_nxt, p2_nxt;
  logic       c1, c2;

  // Per-player SELECT behaviour: returns {locked, num}.
  // A confirm edge blocks any move in the same cycle; confirm together with
  // cancel leaves the lock unchanged.
  function automatic logic [4:0] player_next(input logic [3:0] num,
                                             input logic       locked,
                                             input logic [3:0] e);
    logic [3:0] n;
    logic       l;
    n = num;
    l = locked;
    if (!locked) begin
      if (e[1] && !e[0]) begin
        l = 1'b1;
      end else if (!e[1] && e[2] && !e[3]) begin
        n = (num == LAST_CHAR) ? 4'd0 : num + 4'd1;
      end else if (!e[1] && e[3] && !e[2]) begin
        n = (num == 4'd0) ? LAST_CHAR : num - 4'd1;
      end
    end else if (e[0] && !e[1]) begin
      l = 1'b0;
    end
    return {l, n};
  endfunction

  // Register key levels and their previous values for rising-edge detection
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      k1_q      <= 4'd0;
      k1_prev_q <= 4'd0;
      k2_q      <= 4'd0;
      k2_prev_q <= 4'd0;
    end else begin
      k1_q      <= {p1_left, p1_right, p1_confirm, p1_cancel};
      k1_prev_q <= k1_q;
      k2_q      <= {p2_left, p2_right, p2_confirm, p2_cancel};
      k2_prev_q <= k2_q;
    end
  end

  assign e1     = k1_q & ~k1_prev_q;
  assign e2     = k2_q & ~k2_prev_q;
  assign p1_nxt = player_next(n1_q, l1_q, e1);
  assign p2_nxt = player_next(n2_q, l2_q, e2);
  assign c1     = l1_q && e1[0] && !e1[1];
  assign c2     = l2_q && e2[0] && !e2[1];

  // State, cursor, lock, countdown and pulse registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      n1_q    <= 4'd0;
      n2_q    <= LAST_CHAR;
      l1_q    <= 1'b0;
      l2_q    <= 1'b0;
      cd_q    <= 8'd0;
      ms_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      cd_q    <= cd_d;
      ms_q    <= ms_d;
    end
  end

  // Next-state and datapath updates for the select flow
  always_comb begin
    state_d = state_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    cd_d    = cd_q;
    ms_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (menu_enable) begin
          state_d = S_SELECT;
          l1_d    = 1'b0;
          l2_d    = 1'b0;
        end
      end
      S_SELECT: begin
        if (!menu_enable) begin
          state_d = S_IDLE;
          l1_d    = 1'b0;
          l2_d    = 1'b0;
          cd_d    = 8'd0;
        end else begin
          {l1_d, n1_d} = p1_nxt;
          {l2_d, n2_d} = p2_nxt;
          if (l1_d && l2_d) begin
            state_d = S_COUNT;
            cd_d    = CD_LOAD;
          end
        end
      end
      S_COUNT: begin
        if (!menu_enable) begin
          state_d = S_IDLE;
          l1_d    = 1'b0;
          l2_d    = 1'b0;
          cd_d    = 8'd0;
        end else if (c1 || c2) begin
          // A cancel beats a coincident final tick
          state_d = S_SELECT;
          l1_d    = l1_q && !c1;
          l2_d    = l2_q && !c2;
          cd_d    = 8'd0;
        end else if (frame_tick) begin
          if (cd_q == 8'd1) begin
            state_d = S_DONE;
            cd_d    = 8'd0;
            ms_d    = 1'b1;
          end else begin
            cd_d = cd_q - 8'd1;
          end
        end
      end
      S_DONE: begin
        if (!menu_enable) begin
          state_d = S_IDLE;
          l1_d    = 1'b0;
          l2_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Player_One_Char_Num = n1_q;
  assign Player_Two_Char_Num = n2_q;
  assign p1_locked           = l1_q;
  assign p2_locked           = l2_q;
  assign countdown           = cd_q;
  assign select_state        = state_q;
  assign match_start         = ms_q;

endmodule

// File: tb/tb_char_select_ctrl.sv
// Bench for char_select_ctrl: directed vector table, hand sequences for the
// countdown / cancel / async-reset cases, then random stimulus against a model.
module tb_char_select_ctrl;

  localparam int NC = 4;
  localparam int CF = 3;

  // key bundle {left, right, confirm, cancel}
  localparam int KL = 8;
  localparam int KR = 4;
  localparam int KC = 2;
  localparam int KX = 1;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       menu_enable = 1'b0;
  logic [3:0] k1 = 4'd0;
  logic [3:0] k2 = 4'd0;
  logic [3:0] n1_o, n2_o;
  logic       l1_o, l2_o, ms_o;
  logic [7:0] cd_o;
  logic [1:0] st_o;

  int n_cmp = 0;
  int n_bad = 0;

  char_select_ctrl #(.NUM_CHARS(NC), .COUNTDOWN_FRAMES(CF)) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .menu_enable(menu_enable),
    .p1_left(k1[3]), .p1_right(k1[2]), .p1_confirm(k1[1]), .p1_cancel(k1[0]),
    .p2_left(k2[3]), .p2_right(k2[2]), .p2_confirm(k2[1]), .p2_cancel(k2[0]),
    .Player_One_Char_Num(n1_o), .Player_Two_Char_Num(n2_o),
    .p1_locked(l1_o), .p2_locked(l2_o), .countdown(cd_o),
    .select_state(st_o), .match_start(ms_o)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 select, 2 countdown, 3 done
  int         m_mode;
  int         m_num [2];
  bit         m_lk  [2];
  int         m_cd;
  bit         m_ms;
  logic [3:0] m_seen  [2];
  logic [3:0] m_older [2];

  task automatic model_reset();
    m_mode = 0;
    m_num[0] = 0;
    m_num[1] = NC - 1;
    m_lk[0] = 0;
    m_lk[1] = 0;
    m_cd = 0;
    m_ms = 0;
    for (int p = 0; p < 2; p++) begin
      m_seen[p]  = 4'd0;
      m_older[p] = 4'd0;
    end
  endtask

  task automatic model_edge();
    logic [3:0] e [2];
    logic [3:0] kin [2];
    bit back;
    kin[0] = k1;
    kin[1] = k2;
    if (Reset) begin
      model_reset();
      return;
    end
    for (int p = 0; p < 2; p++) e[p] = m_seen[p] & ~m_older[p];
    m_ms = 0;
    if (!menu_enable) begin
      if (m_mode != 0) begin
        m_mode = 0;
        m_lk[0] = 0;
        m_lk[1] = 0;
        m_cd = 0;
      end
    end else begin
      case (m_mode)
        0: begin
          m_mode = 1;
          m_lk[0] = 0;
          m_lk[1] = 0;
        end
        1: begin
          for (int p = 0; p < 2; p++) begin
            bit lft, rgt, cnf, cnc;
            {lft, rgt, cnf, cnc} = e[p];
            if (!m_lk[p]) begin
              if (cnf && !cnc) m_lk[p] = 1;
              else if (!cnf && rgt && !lft) m_num[p] = (m_num[p] + 1) % NC;
              else if (!cnf && lft && !rgt) m_num[p] = (m_num[p] + NC - 1) % NC;
            end else if (cnc && !cnf) begin
              m_lk[p] = 0;
            end
          end
          if (m_lk[0] && m_lk[1]) begin
            m_mode = 2;
            m_cd = CF;
          end
        end
        2: begin
          back = 0;
          for (int p = 0; p < 2; p++)
            if (e[p][0] && !e[p][1]) begin
              m_lk[p] = 0;
              back = 1;
            end
          if (back) begin
            m_mode = 1;
            m_cd = 0;
          end else if (frame_tick) begin
            m_cd = m_cd - 1;
            if (m_cd == 0) begin
              m_mode = 3;
              m_ms = 1;
            end
          end
        end
        default: ;
      endcase
    end
    for (int p = 0; p < 2; p++) begin
      m_older[p] = m_seen[p];
      m_seen[p]  = kin[p];
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int n1, input int n2,
                           input int l1, input int l2, input int st,
                           input int cd, input int ms);
    chk({tag, ".p1_num"}, int'(n1_o), n1);
    chk({tag, ".p2_num"}, int'(n2_o), n2);
    chk({tag, ".p1_locked"}, int'(l1_o), l1);
    chk({tag, ".p2_locked"}, int'(l2_o), l2);
    chk({tag, ".state"}, int'(st_o), st);
    chk({tag, ".countdown"}, int'(cd_o), cd);
    chk({tag, ".match_start"}, int'(ms_o), ms);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input int m, input int ft, input int a, input int b);
    menu_enable = (m != 0);
    frame_tick  = (ft != 0);
    k1 = 4'(a);
    k2 = 4'(b);
  endtask

  typedef struct packed {
    logic       menu;
    logic       ft;
    logic [3:0] k1;
    logic [3:0] k2;
    logic [3:0] n1;
    logic [3:0] n2;
    logic       l1;
    logic       l2;
    logic [1:0] st;
    logic [7:0] cd;
    logic       ms;
  } vec_t;

  function automatic vec_t mk(input int a, input int b, input int n1,
                              input int n2, input int l1);
    vec_t v;
    v.menu = 1'b1;
    v.ft   = 1'b0;
    v.k1   = 4'(a);
    v.k2   = 4'(b);
    v.n1   = 4'(n1);
    v.n2   = 4'(n2);
    v.l1   = (l1 != 0);
    v.l2   = 1'b0;
    v.st   = 2'b01;
    v.cd   = 8'd0;
    v.ms   = 1'b0;
    return v;
  endfunction

  vec_t tbl [$];

  initial begin
    // cursor stepping, wrap, held-key, lock/freeze/unlock, coincident edges
    tbl.push_back(mk(0, 0, 0, 3, 0));
    tbl.push_back(mk(KR, 0, 0, 3, 0));
    tbl.push_back(mk(0, 0, 1, 3, 0));
    tbl.push_back(mk(KR, 0, 1, 3, 0));
    tbl.push_back(mk(0, 0, 2, 3, 0));
    tbl.push_back(mk(KR, 0, 2, 3, 0));
    tbl.push_back(mk(0, 0, 3, 3, 0));
    tbl.push_back(mk(KR, 0, 3, 3, 0));
    tbl.push_back(mk(0, 0, 0, 3, 0));
    tbl.push_back(mk(0, KL, 0, 3, 0));
    tbl.push_back(mk(0, 0, 0, 2, 0));
    tbl.push_back(mk(KC, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 2, 1));
    tbl.push_back(mk(KR, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 2, 1));
    tbl.push_back(mk(KX, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 2, 0));
    tbl.push_back(mk(KR, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0));
    tbl.push_back(mk(KL | KR, 0, 1, 2, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0));
    tbl.push_back(mk(KL, 0, 1, 2, 0));
    tbl.push_back(mk(0, 0, 0, 2, 0));
    tbl.push_back(mk(KC | KR, 0, 0, 2, 0));
    tbl.push_back(mk(0, 0, 0, 2, 1));
    tbl.push_back(mk(KC | KX, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 2, 1));
    tbl.push_back(mk(KX, 0, 0, 2, 1));
    tbl.push_back(mk(0, 0, 0, 2, 0));

    model_reset();
    drive(0, 0, 0, 0);
    repeat (2) tick();
    Reset = 1'b0;
    check_all("reset", 0, 3, 0, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      menu_enable = tbl[i].menu;
      frame_tick  = tbl[i].ft;
      k1 = tbl[i].k1;
      k2 = tbl[i].k2;
      tick();
      check_all($sformatf("vec%0d", i), int'(tbl[i].n1), int'(tbl[i].n2),
                int'(tbl[i].l1), int'(tbl[i].l2), int'(tbl[i].st),
                int'(tbl[i].cd), int'(tbl[i].ms));
    end

    // P2 holds right for 50 cycles: exactly one step
    for (int i = 0; i < 50; i++) begin
      drive(1, 0, 0, KR);
      tick();
      chk($sformatf("hold%0d.p2_num", i), int'(n2_o), (i == 0) ? 2 : 3);
    end
    drive(1, 0, 0, 0);
    tick();
    check_all("hold_rel", 0, 3, 0, 0, 1, 0, 0);

    // both lock, countdown 3,2,1,0 then DONE with a one-cycle match_start
    drive(1, 0, KC, KC); tick();
    drive(1, 0, 0, 0);   tick();
    check_all("cd_load", 0, 3, 1, 1, 2, 3, 0);
    drive(1, 1, 0, 0); tick(); check_all("cd_2", 0, 3, 1, 1, 2, 2, 0);
    drive(1, 0, 0, 0); tick(); check_all("cd_2h", 0, 3, 1, 1, 2, 2, 0);
    drive(1, 1, 0, 0); tick(); check_all("cd_1", 0, 3, 1, 1, 2, 1, 0);
    drive(1, 0, 0, 0); tick();
    drive(1, 1, 0, 0); tick(); check_all("done", 0, 3, 1, 1, 3, 0, 1);
    drive(1, 0, 0, 0); tick(); check_all("done_hold", 0, 3, 1, 1, 3, 0, 0);
    drive(1, 1, KR, KL); tick(); tick();
    drive(1, 0, 0, 0); tick(); check_all("done_keys", 0, 3, 1, 1, 3, 0, 0);
    drive(0, 0, 0, 0); tick(); check_all("done_exit", 0, 3, 0, 0, 0, 0, 0);

    // cancel coincident with a tick at countdown 2, then full reload
    drive(1, 0, 0, 0); tick(); check_all("reenter", 0, 3, 0, 0, 1, 0, 0);
    drive(1, 0, KC, KC); tick();
    drive(1, 0, 0, 0);   tick(); check_all("relock", 0, 3, 1, 1, 2, 3, 0);
    drive(1, 1, 0, 0);   tick(); check_all("cd2b", 0, 3, 1, 1, 2, 2, 0);
    drive(1, 0, 0, KX);  tick(); check_all("cxl_cap", 0, 3, 1, 1, 2, 2, 0);
    drive(1, 1, 0, 0);   tick(); check_all("cxl_tick", 0, 3, 1, 0, 1, 0, 0);
    drive(1, 0, 0, KC);  tick();
    drive(1, 0, 0, 0);   tick(); check_all("reload", 0, 3, 1, 1, 2, 3, 0);
    drive(1, 1, 0, 0);   tick(); check_all("cd2c", 0, 3, 1, 1, 2, 2, 0);
    drive(1, 0, KR, 0);

    // asynchronous reset mid-countdown, no clock edge needed
    #2 Reset = 1'b1;
    #1 check_all("async_rst", 0, 3, 0, 0, 0, 0, 0);
    model_reset();
    tick();
    Reset = 1'b0;
    drive(1, 0, 0, 0);
    tick(); check_all("post_rst", 0, 3, 0, 0, 1, 0, 0);

    // random stimulus against the model
    Reset = 1'b1;
    model_reset();
    tick();
    Reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] a, b;
      for (int j = 0; j < 4; j++) begin
        a[j] = ($urandom_range(0, 3) == 0);
        b[j] = ($urandom_range(0, 3) == 0);
      end
      menu_enable = ($urandom_range(0, 39) != 0);
      frame_tick  = ($urandom_range(0, 2) == 0);
      k1 = a;
      k2 = b;
      tick();
      check_all($sformatf("rnd%0d", i), m_num[0], m_num[1], int'(m_lk[0]),
                int'(m_lk[1]), m_mode, m_cd, int'(m_ms));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
